// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder-sharing arbiter.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ADD_LAT_MAX = 8;

  // Index width for n items; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above 'last', wrapping.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one external adder between NREQ valid/ready requesters and
// returns each result, tagged with the owner's index, on one response channel.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [id_w(NREQ)-1:0]    resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_cout
);

  localparam int IDW = id_w(NREQ);
  localparam int CW  = id_w(ADD_LAT_MAX);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic             resp_cout_q, resp_cout_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    wait_d      = wait_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    resp_id_d   = resp_id_q;
    resp_sum_d  = resp_sum_q;
    resp_cout_d = resp_cout_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          add_a_d = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
          add_b_d = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          wait_d  = CW'(ADD_LAT - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (wait_q != '0) begin
          wait_d = wait_q - CW'(1);
        end else begin
          resp_sum_d  = add_sum;
          resp_cout_d = add_cout;
          resp_id_d   = id_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants only from IDLE, and never while reset is held.
  assign req_ready  = (state_q == IDLE && !rst) ? gnt : '0;
  assign resp_valid = (state_q == RESP);
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      wait_q      <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      resp_id_q   <= '0;
      resp_sum_q  <= '0;
      resp_cout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      wait_q      <= wait_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      resp_id_q   <= resp_id_d;
      resp_sum_q  <= resp_sum_d;
      resp_cout_q <= resp_cout_d;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench: one DUT with a combinational adder, one with a 3-edge adder.
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        resp_ready = 1'b0;

  logic [3:0]  req_ready1, req_ready3;
  logic [3:0]  add_a1, add_b1, add_sum1, add_a3, add_b3, add_sum3;
  logic        add_cout1, add_cout3;
  logic        resp_valid1, resp_valid3;
  logic [1:0]  resp_id1, resp_id3;
  logic [3:0]  resp_sum1, resp_sum3;
  logic        resp_cout1, resp_cout3;

  logic [4:0]  p1_3 = '0;
  logic [4:0]  p2_3 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1};

  always @(posedge clk) begin
    p1_3 <= {1'b0, add_a3} + {1'b0, add_b3};
    p2_3 <= p1_3;
  end
  assign {add_cout3, add_sum3} = p2_3;

  adder_share_arbiter #(.NREQ(4), .WIDTH(4), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .add_a(add_a1), .add_b(add_b1),
    .add_sum(add_sum1), .add_cout(add_cout1), .resp_valid(resp_valid1),
    .resp_ready(resp_ready), .resp_id(resp_id1), .resp_sum(resp_sum1),
    .resp_cout(resp_cout1)
  );

  adder_share_arbiter #(.NREQ(4), .WIDTH(4), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .add_a(add_a3), .add_b(add_b3),
    .add_sum(add_sum3), .add_cout(add_cout3), .resp_valid(resp_valid3),
    .resp_ready(resp_ready), .resp_id(resp_id3), .resp_sum(resp_sum3),
    .resp_cout(resp_cout3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    set_op(0, 4'h5, 4'h6);
    step();
    n_checks++;
    if (req_ready1 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready1);
    end
    n_checks++;
    if (add_a1 !== 4'h0 || add_b1 !== 4'h0) begin
      n_fail++; $display("FAIL reset_add: got a=%h b=%h want 0 0", add_a1, add_b1);
    end
    n_checks++;
    if (resp_valid1 !== 1'b0 || resp_id1 !== 2'd0 || resp_sum1 !== 4'h0 || resp_cout1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: got v=%b id=%0d s=%h c=%b want 0 0 0 0",
               resp_valid1, resp_id1, resp_sum1, resp_cout1);
    end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_op(2, 4'hF, 4'h1);
    req_valid = 4'b0100;
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready1 !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready1);
    end
    step();
    req_valid = '0;
    #1;
    n_checks++;
    if (req_ready1 !== 4'b0000 || resp_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: got rdy=%b v=%b want 0000 0", req_ready1, resp_valid1);
    end
    n_checks++;
    if (add_a1 !== 4'hF || add_b1 !== 4'h1) begin
      n_fail++; $display("FAIL single_operands: got a=%h b=%h want f 1", add_a1, add_b1);
    end
    step();
    n_checks++;
    if (resp_valid1 !== 1'b1 || resp_id1 !== 2'd2 || resp_sum1 !== 4'h0 || resp_cout1 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_resp: got v=%b id=%0d s=%h c=%b want 1 2 0 1",
               resp_valid1, resp_id1, resp_sum1, resp_cout1);
    end
    step();
    n_checks++;
    if (resp_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got v=%b want 0", resp_valid1);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_sum [4];
    logic       exp_cout [4];
    exp_sum = '{4'h7, 4'hF, 4'h1, 4'h1};
    exp_cout = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    set_op(0, 4'h3, 4'h4);
    set_op(1, 4'h6, 4'h9);
    set_op(2, 4'hA, 4'h7);
    set_op(3, 4'hC, 4'h5);
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      n_checks++;
      if (req_ready1 !== (4'b0001 << (n % 4))) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready1, 4'b0001 << (n % 4));
      end
      step();
      step();
      n_checks++;
      if (resp_valid1 !== 1'b1 || resp_id1 !== 2'(n % 4) ||
          resp_sum1 !== exp_sum[n % 4] || resp_cout1 !== exp_cout[n % 4]) begin
        n_fail++;
        $display("FAIL rr_resp%0d: got v=%b id=%0d s=%h c=%b want 1 %0d %h %b", n,
                 resp_valid1, resp_id1, resp_sum1, resp_cout1, n % 4,
                 exp_sum[n % 4], exp_cout[n % 4]);
      end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(0, 4'h5, 4'hA);
    set_op(1, 4'h7, 4'h8);
    req_valid = 4'b0011;
    resp_ready = 1'b0;
    #1;
    n_checks++;
    if (req_ready1 !== 4'b0001) begin
      n_fail++; $display("FAIL bp_grant0: got %b want 0001", req_ready1);
    end
    step();
    req_valid = 4'b0010;
    step();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (resp_valid1 !== 1'b1 || resp_id1 !== 2'd0 || resp_sum1 !== 4'hF ||
          resp_cout1 !== 1'b0 || req_ready1 !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d s=%h c=%b rdy=%b want 1 0 f 0 0000", k,
                 resp_valid1, resp_id1, resp_sum1, resp_cout1, req_ready1);
      end
      step();
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready1 !== 4'b0000) begin
      n_fail++; $display("FAIL bp_handshake_ready: got %b want 0000", req_ready1);
    end
    step();
    n_checks++;
    if (req_ready1 !== 4'b0010 || resp_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL bp_grant1: got rdy=%b v=%b want 0010 0", req_ready1, resp_valid1);
    end
    step();
    req_valid = '0;
    step();
    n_checks++;
    if (resp_valid1 !== 1'b1 || resp_id1 !== 2'd1 || resp_sum1 !== 4'hF || resp_cout1 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_resp1: got v=%b id=%0d s=%h c=%b want 1 1 f 0",
               resp_valid1, resp_id1, resp_sum1, resp_cout1);
    end
    step();
  endtask

  task automatic test_latency3();
    do_reset();
    set_op(0, 4'h9, 4'h9);
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready3 !== 4'b0001) begin
      n_fail++; $display("FAIL lat3_grant: got %b want 0001", req_ready3);
    end
    step();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (resp_valid3 !== 1'b0 || add_a3 !== 4'h9 || add_b3 !== 4'h9) begin
        n_fail++;
        $display("FAIL lat3_busy%0d: got v=%b a=%h b=%h want 0 9 9", k, resp_valid3, add_a3, add_b3);
      end
      step();
    end
    n_checks++;
    if (resp_valid3 !== 1'b1 || resp_id3 !== 2'd0 || resp_sum3 !== 4'h2 || resp_cout3 !== 1'b1) begin
      n_fail++;
      $display("FAIL lat3_resp: got v=%b id=%0d s=%h c=%b want 1 0 2 1",
               resp_valid3, resp_id3, resp_sum3, resp_cout3);
    end
    step();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    set_op(0, 4'h2, 4'h3);
    set_op(3, 4'h4, 4'h4);
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    step();
    req_valid = '0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (add_a1 !== 4'h0 || add_b1 !== 4'h0 || req_ready1 !== 4'b0000 || resp_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got a=%h b=%h rdy=%b v=%b want 0 0 0000 0",
               add_a1, add_b1, req_ready1, resp_valid1);
    end
    step();
    n_checks++;
    if (resp_valid1 !== 1'b0 || resp_sum1 !== 4'h0 || resp_id1 !== 2'd0 || resp_cout1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_noresp: got v=%b id=%0d s=%h c=%b want 0 0 0 0",
               resp_valid1, resp_id1, resp_sum1, resp_cout1);
    end
    rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    n_checks++;
    if (req_ready1 !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_first_grant: got %b want 0001", req_ready1);
    end
    step();
    req_valid = 4'b1000;
    step();
    n_checks++;
    if (resp_valid1 !== 1'b1 || resp_id1 !== 2'd0 || resp_sum1 !== 4'h5 || resp_cout1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_resp: got v=%b id=%0d s=%h c=%b want 1 0 5 0",
               resp_valid1, resp_id1, resp_sum1, resp_cout1);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_withdrawn();
    do_reset();
    set_op(0, 4'h1, 4'h1);
    set_op(3, 4'hE, 4'hE);
    req_valid = 4'b0001;
    resp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b1000;
    #1;
    n_checks++;
    if (req_ready1 !== 4'b0000 || resp_valid1 !== 1'b1) begin
      n_fail++; $display("FAIL wd_resp_ready: got rdy=%b v=%b want 0000 1", req_ready1, resp_valid1);
    end
    step();
    req_valid = '0;
    resp_ready = 1'b1;
    step();
    n_checks++;
    if (req_ready1 !== 4'b0000 || resp_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL wd_idle: got rdy=%b v=%b want 0000 0", req_ready1, resp_valid1);
    end
    step();
    step();
    n_checks++;
    if (req_ready1 !== 4'b0000 || resp_valid1 !== 1'b0 || add_a1 !== 4'h1 || add_b1 !== 4'h1) begin
      n_fail++;
      $display("FAIL wd_no_grant: got rdy=%b v=%b a=%h b=%h want 0000 0 1 1",
               req_ready1, resp_valid1, add_a1, add_b1);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_latency3();
    test_reset_mid_busy();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
